// File: rtl/seq_shifter8.sv
// rtl/seq_shifter8.sv - iterative one-bit-per-clock shift/rotate unit with start/busy/done handshake
// Supports LSL, LSR, ASR, ROR and ROL; the last bit moved out is reported as carry.
module seq_shifter8 #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  state_t           r_state;
  logic [AMT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_work;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_legal;
  logic [WIDTH-1:0] w_next;
  logic             w_out;

  assign w_accept = start && !r_busy;
  assign w_legal  = (op <= OP_ROL);

  // One-position step of the latched operation and the bit it pushes out.
  always_comb begin
    w_next = r_work;
    w_out  = 1'b0;
    case (r_op)
      OP_LSL: begin
        w_out  = r_work[WIDTH-1];
        w_next = {r_work[WIDTH-2:0], 1'b0};
      end
      OP_LSR: begin
        w_out  = r_work[0];
        w_next = {1'b0, r_work[WIDTH-1:1]};
      end
      OP_ASR: begin
        w_out  = r_work[0];
        w_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      end
      OP_ROR: begin
        w_out  = r_work[0];
        w_next = {r_work[0], r_work[WIDTH-1:1]};
      end
      OP_ROL: begin
        w_out  = r_work[WIDTH-1];
        w_next = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
      end
      default: begin
        w_out  = 1'b0;
        w_next = r_work;
      end
    endcase
  end

  // A reserved op loads a zero count so it drains through SHIFT as a pass-through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
            r_work  <= a;
            r_op    <= op;
            r_cnt   <= w_legal ? amt : '0;
            r_carry <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_work  <= w_next;
            r_carry <= w_out;
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign y     = r_work;
  assign carry = r_carry;

endmodule

// File: tb/tb_seq_shifter8.sv
// tb/tb_seq_shifter8.sv - scoreboard bench for seq_shifter8
// Driver pushes expected results on accepted starts; a negedge monitor pops on done.
module tb_seq_shifter8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'd0;
  logic [2:0] amt = 3'd0;
  logic       busy;
  logic       done;
  logic [7:0] y;
  logic       carry;

  typedef struct {
    logic [7:0] y;
    logic       c;
    int         acc;
    int         dc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  seq_shifter8 #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .amt(amt),
    .busy(busy), .done(done), .y(y), .carry(carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  // Reference computed from whole-amount arithmetic rather than bit stepping.
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] av, input logic [2:0] n);
    exp_t e;
    int k;
    logic [7:0] t;
    k = int'(n);
    e.acc = 0;
    e.dc = 0;
    case (o)
      3'd0: begin t = av << k; e.c = (k != 0) ? av[8-k] : 1'b0; end
      3'd1: begin t = av >> k; e.c = (k != 0) ? av[k-1] : 1'b0; end
      3'd2: begin t = 8'($signed(av) >>> k); e.c = (k != 0) ? av[k-1] : 1'b0; end
      3'd3: begin t = (av >> k) | (av << (8 - k)); e.c = (k != 0) ? t[7] : 1'b0; end
      3'd4: begin t = (av << k) | (av >> (8 - k)); e.c = (k != 0) ? t[0] : 1'b0; end
      default: begin t = av; e.c = 1'b0; end
    endcase
    e.y = t;
    return e;
  endfunction

  // Called just after a rising edge; holds start for exactly one edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] av, input logic [2:0] n,
                       input bit use_exp, input logic [7:0] ey, input logic ec);
    exp_t e;
    start = 1'b1;
    op = o;
    a = av;
    amt = n;
    if (!busy) begin
      e = model(o, av, n);
      if (use_exp) begin
        e.y = ey;
        e.c = ec;
      end
      e.acc = cyc + 1;
      e.dc = e.acc + ((o <= 3'd4) ? int'(n) : 0) + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() > 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_timeout", q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit exp_busy;
    if (!reset) begin
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("y", y, e.y);
          check("carry", carry, e.c);
          check("done_cycle", cyc, e.dc);
        end
      end else if (q.size() > 0 && cyc >= q[0].dc) begin
        e = q.pop_front();
        check("done_missing", 0, 1);
      end
      exp_busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].dc);
      check("busy", busy, exp_busy);
    end
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_y", y, 8'h00);
    check("rst_carry", carry, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    issue(3'd0, 8'hB1, 3'd3, 1, 8'h88, 1'b1); drain();
    issue(3'd2, 8'h90, 3'd2, 1, 8'hE4, 1'b0); drain();
    issue(3'd1, 8'h90, 3'd2, 1, 8'h24, 1'b0); drain();
    issue(3'd3, 8'h81, 3'd1, 1, 8'hC0, 1'b1); drain();
    issue(3'd4, 8'h81, 3'd7, 1, 8'hC0, 1'b0); drain();
    issue(3'd1, 8'h5A, 3'd0, 1, 8'h5A, 1'b0); drain();
    issue(3'd6, 8'h3D, 3'd5, 1, 8'h3D, 1'b0); drain();

    issue(3'd0, 8'h3C, 3'd5, 1, 8'h80, 1'b1);
    issue(3'd0, 8'hFF, 3'd1, 1, 8'hFE, 1'b1);
    drain();

    issue(3'd1, 8'hF0, 3'd2, 1, 8'h3C, 1'b0);
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk);
      #1;
    end
    check("b2b_done_seen", done, 1);
    issue(3'd4, 8'h12, 3'd3, 1, 8'h90, 1'b0);
    drain();

    issue(3'd4, 8'hA5, 3'd6, 0, 8'h00, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_y", y, 8'h00);
    check("abort_carry", carry, 0);
    q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    issue(3'd0, 8'h01, 3'd7, 1, 8'h80, 1'b0); drain();

    repeat (1500) begin
      if ($urandom_range(2) == 0)
        issue(3'($urandom_range(7)), 8'($urandom), 3'($urandom_range(7)), 0, 8'h00, 1'b0);
      else begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
